// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: interlock-only hazard unit for a 5-stage pipeline with no
// forwarding. Detects RAW hazards between decode sources and the E/M/W
// destinations, stalls F/D while bubbling D/E for the required number of
// cycles, and gives a taken redirect priority over any stall.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise the counter ports are tied to zero.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_write_E,
  input  logic             reg_write_M,
  input  logic             reg_write_W,
  input  logic             pc_sel_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  state_t     state;
  logic [1:0] rem;
  logic       hit_E;
  logic       hit_M;
  logic       hit_W;
  logic [1:0] need;

  // Hazard detection: youngest matching producer sets the stall length.
  always_comb begin
    hit_E = reg_write_E && (rd_E != '0) &&
            ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));
    hit_M = reg_write_M && (rd_M != '0) &&
            ((use_rs1_D && (rs1_D == rd_M)) || (use_rs2_D && (rs2_D == rd_M)));
    hit_W = reg_write_W && (rd_W != '0) &&
            ((use_rs1_D && (rs1_D == rd_W)) || (use_rs2_D && (rs2_D == rd_W)));
    if (hit_E)      need = 2'd3;
    else if (hit_M) need = 2'd2;
    else if (hit_W) need = 2'd1;
    else            need = 2'd0;
  end

  // Control outputs: redirect beats stall; reset forces everything low
  // immediately since these are combinational.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (!rst_i) begin
      if (pc_sel_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if ((state == STALL) || (need != 2'd0)) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Stall sequencer: the first stall cycle is issued from RUN, remaining
  // cycles are counted down in STALL without re-evaluating hazards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      rem   <= '0;
    end else if (pc_sel_E) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (need != 2'd0) begin
            rem   <= need - 2'd1;
            state <= (need > 2'd1) ? STALL : RUN;
          end
        end
        STALL: begin
          rem <= rem - 2'd1;
          if (rem == 2'd1) state <= RUN;
        end
        default: begin
          state <= RUN;
          rem   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters for stall and redirect cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_D && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (pc_sel_E && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-countdown reference model.
module tb_hazard_stall_ctrl;

  localparam int unsigned TB_CNT_W = 4;
  localparam int MAXV = (1 << TB_CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [4:0]          rs1_D, rs2_D, rd_E, rd_M, rd_W;
  logic                use_rs1_D, use_rs2_D;
  logic                reg_write_E, reg_write_M, reg_write_W;
  logic                pc_sel_E;
  logic                stall_F, stall_D, flush_D, flush_E;
  logic [TB_CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  hazard_stall_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .pc_sel_E(pc_sel_E),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding stall cycles and event tallies.
  int m_left = 0;
  int m_scnt = 0;
  int m_fcnt = 0;
  logic [3:0]          exp_ctrl;
  logic [TB_CNT_W-1:0] exp_scnt, exp_fcnt;
  logic [3:0]          obs_ctrl;

  assign obs_ctrl = {stall_F, stall_D, flush_D, flush_E};

  function automatic bit reads(input logic [4:0] rd, input logic we);
    return we && (rd != 5'd0) &&
           ((use_rs1_D && rs1_D == rd) || (use_rs2_D && rs2_D == rd));
  endfunction

  // Stall cycles the decode instruction must wait: distance to the producer.
  function automatic int model_need();
    if (reads(rd_E, reg_write_E)) return 3;
    if (reads(rd_M, reg_write_M)) return 2;
    if (reads(rd_W, reg_write_W)) return 1;
    return 0;
  endfunction

  // Let inputs settle and compute what the outputs should be this cycle.
  task automatic settle();
    #3;
    if (rst_i)                                  exp_ctrl = 4'b0000;
    else if (pc_sel_E)                          exp_ctrl = 4'b0011;
    else if (m_left > 0 || model_need() > 0)    exp_ctrl = 4'b1101;
    else                                        exp_ctrl = 4'b0000;
    exp_scnt = (rst_i || !PERF) ? '0 : TB_CNT_W'(m_scnt);
    exp_fcnt = (rst_i || !PERF) ? '0 : TB_CNT_W'(m_fcnt);
  endtask

  // Commit the model for this cycle and move to just after the next edge.
  task automatic advance();
    if (rst_i) begin
      m_left = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (exp_ctrl[2] && m_scnt < MAXV) m_scnt++;
      if (pc_sel_E && m_fcnt < MAXV) m_fcnt++;
      if (pc_sel_E)          m_left = 0;
      else if (m_left > 0)   m_left--;
      else if (model_need() > 0) m_left = model_need() - 1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_D = '0; rs2_D = '0; use_rs1_D = 0; use_rs2_D = 0;
    rd_E = '0; rd_M = '0; rd_W = '0;
    reg_write_E = 0; reg_write_M = 0; reg_write_W = 0; pc_sel_E = 0;
  endtask

  task automatic pulse_reset();
    rst_i = 1; clear_inputs(); settle(); advance(); rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; clear_inputs();
    @(posedge clk_i); #1;
    settle();
    checks++;
    if (obs_ctrl !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", obs_ctrl);
    end
    checks++;
    if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o);
    end
    advance();
    rst_i = 0;
  endtask

  // E-distance producer advancing through M and W: exactly 3 stall cycles.
  task automatic test_e_hazard();
    int seen = 0;
    clear_inputs();
    rs1_D = 5; use_rs1_D = 1;
    for (int k = 0; k < 6; k++) begin
      rd_E = (k == 0) ? 5'd5 : 5'd0; reg_write_E = (k == 0);
      rd_M = (k == 1) ? 5'd5 : 5'd0; reg_write_M = (k == 1);
      rd_W = (k == 2) ? 5'd5 : 5'd0; reg_write_W = (k == 2);
      settle();
      checks++;
      if (obs_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL e_hazard_c%0d: got %b want %b", k, obs_ctrl, exp_ctrl);
      end
      checks++;
      if (obs_ctrl !== ((k < 3) ? 4'b1101 : 4'b0000)) begin
        errors++; $display("FAIL e_hazard_fixed_c%0d: got %b", k, obs_ctrl);
      end
      if (stall_D === 1'b1) seen++;
      advance();
    end
    checks++;
    if (seen != 3) begin
      errors++; $display("FAIL e_hazard_len: got %0d want 3", seen);
    end
  endtask

  // M-distance, W-distance and x0 destination.
  task automatic test_m_w_zero();
    int want[3] = '{2, 1, 0};
    for (int sc = 0; sc < 3; sc++) begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        clear_inputs();
        if (k == 0) begin
          use_rs2_D = 1;
          if (sc == 0)      begin rs2_D = 7; rd_M = 7; reg_write_M = 1; end
          else if (sc == 1) begin rs2_D = 7; rd_W = 7; reg_write_W = 1; end
          else              begin rs2_D = 0; rd_E = 0; reg_write_E = 1; end
        end
        settle();
        checks++;
        if (obs_ctrl !== exp_ctrl) begin
          errors++; $display("FAIL mwz_s%0d_c%0d: got %b want %b", sc, k, obs_ctrl, exp_ctrl);
        end
        if (stall_D === 1'b1) seen++;
        advance();
      end
      checks++;
      if (seen != want[sc]) begin
        errors++; $display("FAIL mwz_len_s%0d: got %0d want %0d", sc, seen, want[sc]);
      end
    end
  endtask

  // Redirect in the second cycle of a 3-cycle stall.
  task automatic test_redirect();
    logic [3:0] want[3] = '{4'b1101, 4'b0011, 4'b0000};
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      if (k == 0) begin rs1_D = 9; use_rs1_D = 1; rd_E = 9; reg_write_E = 1; end
      if (k == 1) pc_sel_E = 1;
      settle();
      checks++;
      if (obs_ctrl !== want[k] || obs_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL redirect_c%0d: got %b want %b", k, obs_ctrl, want[k]);
      end
      advance();
    end
  endtask

  // Asynchronous reset in the middle of a stall.
  task automatic test_async_reset();
    clear_inputs();
    rs1_D = 3; use_rs1_D = 1; rd_E = 3; reg_write_E = 1;
    settle(); advance();
    clear_inputs();
    settle();
    checks++;
    if (obs_ctrl !== 4'b1101) begin
      errors++; $display("FAIL areset_pre: got %b want 1101", obs_ctrl);
    end
    #1 rst_i = 1;
    #1;
    checks++;
    if (obs_ctrl !== 4'b0000 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      errors++; $display("FAIL areset_now: ctrl %b cnt %0d/%0d want 0000 0/0",
                         obs_ctrl, stall_cnt_o, flush_cnt_o);
    end
    settle(); advance();
    rst_i = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (obs_ctrl !== 4'b0000 || obs_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL areset_after_c%0d: got %b want 0000", k, obs_ctrl);
      end
      advance();
    end
  endtask

  task automatic test_counters();
    pulse_reset();
    for (int k = 0; k < 7; k++) begin
      clear_inputs();
      if (k == 0) begin rs2_D = 4; use_rs2_D = 1; rd_E = 4; reg_write_E = 1; end
      if (k == 4 || k == 5) pc_sel_E = 1;
      settle(); advance();
    end
    settle();
    checks++;
    if (stall_cnt_o !== (PERF ? 4'd3 : 4'd0) || flush_cnt_o !== (PERF ? 4'd2 : 4'd0)) begin
      errors++; $display("FAIL cnt_basic: got %0d/%0d want %0d/%0d",
                         stall_cnt_o, flush_cnt_o, PERF ? 3 : 0, PERF ? 2 : 0);
    end
    for (int k = 0; k < 44; k++) begin
      clear_inputs();
      if (k < 22) begin rs1_D = 2; use_rs1_D = 1; rd_W = 2; reg_write_W = 1; end
      else pc_sel_E = 1;
      settle();
      checks++;
      if (obs_ctrl !== exp_ctrl || stall_cnt_o !== exp_scnt || flush_cnt_o !== exp_fcnt) begin
        errors++; $display("FAIL cnt_sat_c%0d: ctrl %b cnt %0d/%0d want %b %0d/%0d",
                           k, obs_ctrl, stall_cnt_o, flush_cnt_o, exp_ctrl, exp_scnt, exp_fcnt);
      end
      advance();
    end
    clear_inputs();
    settle();
    checks++;
    if (stall_cnt_o !== (PERF ? 4'hF : 4'h0) || flush_cnt_o !== (PERF ? 4'hF : 4'h0)) begin
      errors++; $display("FAIL cnt_saturated: got %0d/%0d want %0d/%0d",
                         stall_cnt_o, flush_cnt_o, PERF ? 15 : 0, PERF ? 15 : 0);
    end
    advance();
  endtask

  task automatic test_random();
    int bad = 0;
    pulse_reset();
    for (int k = 0; k < 2000; k++) begin
      rst_i       = ($urandom_range(0, 99) == 0);
      rs1_D       = 5'($urandom_range(0, 3));
      rs2_D       = 5'($urandom_range(0, 3));
      use_rs1_D   = 1'($urandom_range(0, 1));
      use_rs2_D   = 1'($urandom_range(0, 1));
      rd_E        = 5'($urandom_range(0, 3));
      rd_M        = 5'($urandom_range(0, 3));
      rd_W        = 5'($urandom_range(0, 3));
      reg_write_E = ($urandom_range(0, 2) == 0);
      reg_write_M = ($urandom_range(0, 2) == 0);
      reg_write_W = ($urandom_range(0, 2) == 0);
      pc_sel_E    = ($urandom_range(0, 9) == 0);
      settle();
      checks++;
      if (obs_ctrl !== exp_ctrl || stall_cnt_o !== exp_scnt || flush_cnt_o !== exp_fcnt) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_c%0d: ctrl %b cnt %0d/%0d want %b %0d/%0d",
                   k, obs_ctrl, stall_cnt_o, flush_cnt_o, exp_ctrl, exp_scnt, exp_fcnt);
        bad++;
      end
      advance();
    end
    rst_i = 0;
  endtask

  initial begin
    test_reset();
    test_e_hazard();
    test_m_w_zero();
    test_redirect();
    test_async_reset();
    test_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
